// File: rtl/z80_int_ctrl.sv
// z80_int_ctrl -- prioritised interrupt controller for the Z80 memory/IO system.
//
// Collects NUM_SRC level requests, masks them with a CPU-writable register,
// drives INT_n (mode-2 style vectored), supplies a per-source vector during the
// interrupt-acknowledge cycle and keeps the serviced source in service until an
// end-of-interrupt write or until that source's request drops.
//
// Ports:
//   CLK, RESET_n   Z80 clock, synchronous active-low reset
//   irq_req        level requests (may come from another clock domain)
//   M1_n, IORQ_n,
//   RD_n, WR_n,
//   A, D_in        Z80 bus (A[7:0], write data)
//   INT_n          registered interrupt request to the CPU
//   int_vector     vector byte for the acknowledge cycle
//   int_vec_oe     top level drives int_vector onto D while high
//   io_data        registered read data for MASK / STATUS
//   io_hit         high while an I/O read targets MASK or STATUS
module z80_int_ctrl #(
  parameter int         NUM_SRC       = 4,
  parameter logic [7:0] VECTOR_BASE   = 8'h6C,
  parameter logic [7:0] VECTOR_STEP   = 8'h08,
  parameter logic [7:0] MASK_RESET    = 8'h01,
  parameter logic [7:0] IOADDR_MASK   = 8'h10,
  parameter logic [7:0] IOADDR_STATUS = 8'h11,
  parameter logic [7:0] IOADDR_EOI    = 8'h12
) (
  input  logic               CLK,
  input  logic               RESET_n,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic               M1_n,
  input  logic               IORQ_n,
  input  logic               RD_n,
  input  logic               WR_n,
  input  logic [7:0]         A,
  input  logic [7:0]         D_in,
  output logic               INT_n,
  output logic [7:0]         int_vector,
  output logic               int_vec_oe,
  output logic [7:0]         io_data,
  output logic               io_hit
);

  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_ACK,
    S_SERVICE
  } state_t;

  // Lowest set index wins (index 0 is the highest priority).
  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_SRC-1:0] p);
    lowest_set = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (p[i]) lowest_set = ID_W'(i);
    end
  endfunction

  // 8-bit arithmetic, so the vector wraps mod 256.
  function automatic logic [7:0] vec_of(input logic [ID_W-1:0] id);
    vec_of = VECTOR_BASE + VECTOR_STEP * 8'(id);
  endfunction

  function automatic logic [7:0] zext(input logic [NUM_SRC-1:0] v);
    zext = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      zext[i] = v[i];
    end
  endfunction

  logic [NUM_SRC-1:0] req_p0;
  logic [NUM_SRC-1:0] req_p1;
  logic [NUM_SRC-1:0] req_s;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pend;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    vec_id;
  logic [ID_W-1:0]    isr_id;
  state_t             state;
  logic               ack;
  logic               ack_q;
  logic               ack_rise;
  logic               io_rd;
  logic               io_wr;
  logic               eoi_wr;
  logic               unused_d;

  assign req_s    = req_p1;
  assign pend     = req_s & mask;
  assign win      = lowest_set(pend);

  assign ack      = ~M1_n & ~IORQ_n;
  assign ack_rise = ack & ~ack_q;
  assign io_rd    = ~IORQ_n & ~RD_n & M1_n;
  assign io_wr    = ~IORQ_n & ~WR_n & M1_n;
  assign eoi_wr   = io_wr & (A == IOADDR_EOI);

  assign io_hit     = io_rd & ((A == IOADDR_MASK) | (A == IOADDR_STATUS));
  assign int_vec_oe = ack & ((state == S_ASSERT) | (state == S_ACK));

  // Data bits above NUM_SRC carry nothing for this block.
  assign unused_d = ^D_in;

  // Stage p0/p1: two-flop synchroniser for the asynchronous requests.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      req_p0 <= '0;
      req_p1 <= '0;
    end else begin
      req_p0 <= irq_req;
      req_p1 <= req_p0;
    end
  end

  // Mask register and registered read data.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      mask    <= MASK_RESET[NUM_SRC-1:0];
      io_data <= '0;
    end else begin
      if (io_wr && (A == IOADDR_MASK)) mask <= D_in[NUM_SRC-1:0];
      if (io_rd) begin
        if (A == IOADDR_MASK)        io_data <= zext(mask);
        else if (A == IOADDR_STATUS) io_data <= zext(req_s);
      end
    end
  end

  // vec_id always names the source whose vector sits in int_vector, so the
  // in-service id matches the vector the CPU actually fetched, even when the
  // request vanishes in the same cycle as the acknowledge.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state      <= S_IDLE;
      INT_n      <= 1'b1;
      int_vector <= VECTOR_BASE;
      vec_id     <= '0;
      isr_id     <= '0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= ack;
      case (state)
        S_IDLE: begin
          if (|pend) begin
            INT_n      <= 1'b0;
            int_vector <= vec_of(win);
            vec_id     <= win;
            state      <= S_ASSERT;
          end else begin
            INT_n <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (ack_rise) begin
            INT_n  <= 1'b1;
            isr_id <= vec_id;
            state  <= S_ACK;
          end else if (!(|pend)) begin
            INT_n <= 1'b1;
            state <= S_IDLE;
          end else begin
            int_vector <= vec_of(win);
            vec_id     <= win;
          end
        end
        S_ACK: begin
          if (!ack) state <= S_SERVICE;
        end
        S_SERVICE: begin
          // No nesting: everything is held off until EOI or the source drops.
          if (eoi_wr || !req_s[isr_id]) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Scoreboard bench for z80_int_ctrl: stimulus tasks push expected output
// events (INT_n edges, acknowledge vectors, register reads) into a queue; a
// monitor process pops and compares whenever the DUT shows such an event.
// A second instance with VECTOR_BASE=8'hF8 shares the stimulus to cover the
// vector wrap-around.
module tb_z80_int_ctrl;

  localparam int K_FALL = 0;
  localparam int K_RISE = 1;
  localparam int K_VEC  = 2;
  localparam int K_RD   = 3;

  localparam int PH_IDLE    = 0;
  localparam int PH_ASSERT  = 1;
  localparam int PH_SERVICE = 2;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] v;
    logic [7:0] v2;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic [3:0] irq_req = 4'h0;
  logic       M1_n = 1'b1;
  logic       IORQ_n = 1'b1;
  logic       RD_n = 1'b1;
  logic       WR_n = 1'b1;
  logic [7:0] A = 8'h00;
  logic [7:0] D_in = 8'h00;

  logic       INT_n, INT2_n;
  logic [7:0] int_vector, int_vector2;
  logic       int_vec_oe, int_vec_oe2;
  logic [7:0] io_data, io_data2;
  logic       io_hit, io_hit2;

  z80_int_ctrl dut (
    .CLK(CLK), .RESET_n(RESET_n), .irq_req(irq_req),
    .M1_n(M1_n), .IORQ_n(IORQ_n), .RD_n(RD_n), .WR_n(WR_n),
    .A(A), .D_in(D_in),
    .INT_n(INT_n), .int_vector(int_vector), .int_vec_oe(int_vec_oe),
    .io_data(io_data), .io_hit(io_hit)
  );

  z80_int_ctrl #(.VECTOR_BASE(8'hF8)) dut2 (
    .CLK(CLK), .RESET_n(RESET_n), .irq_req(irq_req),
    .M1_n(M1_n), .IORQ_n(IORQ_n), .RD_n(RD_n), .WR_n(WR_n),
    .A(A), .D_in(D_in),
    .INT_n(INT2_n), .int_vector(int_vector2), .int_vec_oe(int_vec_oe2),
    .io_data(io_data2), .io_hit(io_hit2)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  bit  mon_en = 1'b0;

  // Reference model state (transaction level).
  logic [3:0] m_req = 4'h0;
  logic [3:0] m_mask = 4'h1;
  int         m_phase = PH_IDLE;
  logic [1:0] m_svc = 2'd0;
  logic [7:0] m_last_rd = 8'h00;

  function automatic logic [1:0] lowest(input logic [3:0] p);
    for (int i = 3; i >= 0; i--) begin
      if (p[i]) lowest = 2'(i);
    end
  endfunction

  function automatic logic [7:0] vec_for(input logic [7:0] base, input logic [1:0] id);
    int s;
    s = (int'(base) + 8 * int'(id)) % 256;
    return 8'(s);
  endfunction

  task automatic push(input int kind, input int c, input logic [7:0] v, input logic [7:0] v2);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.v    = v;
    e.v2   = v2;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon_chk(input int kind, input logic [7:0] v, input logic [7:0] v2);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d v=%h v2=%h expected no event",
               kind, cyc, v, v2);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.v !== v || e.v2 !== v2) begin
        bad++;
        $display("FAIL event: got kind=%0d cyc=%0d v=%h v2=%h expected kind=%0d cyc=%0d v=%h v2=%h",
                 kind, cyc, v, v2, e.kind, e.cyc, e.v, e.v2);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic prev_int;
    logic prev_oe;
    bit   rd_flag;
    prev_int = 1'b1;
    prev_oe  = 1'b0;
    rd_flag  = 1'b0;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (rd_flag) mon_chk(K_RD, io_data, io_data2);
        rd_flag = 1'b0;
        if (INT_n !== prev_int)
          mon_chk(INT_n ? K_RISE : K_FALL, {7'd0, INT_n}, {7'd0, INT2_n});
        if (int_vec_oe && !prev_oe)
          mon_chk(K_VEC, int_vector, int_vector2);
        if (io_hit) rd_flag = 1'b1;
      end
      prev_int = INT_n;
      prev_oe  = int_vec_oe;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic apply_req(input logic [3:0] r);
    int c;
    logic [3:0] p;
    c = cyc;
    irq_req = r;
    m_req = r;
    p = r & m_mask;
    if (m_phase == PH_ASSERT && p == 4'h0) begin
      push(K_RISE, c + 3, 8'h01, 8'h01);
      m_phase = PH_IDLE;
    end else if (m_phase == PH_IDLE && p != 4'h0) begin
      push(K_FALL, c + 3, 8'h00, 8'h00);
      m_phase = PH_ASSERT;
    end else if (m_phase == PH_SERVICE && !r[m_svc]) begin
      m_phase = PH_IDLE;
      if (p != 4'h0) begin
        push(K_FALL, c + 4, 8'h00, 8'h00);
        m_phase = PH_ASSERT;
      end
    end
    ticks(6);
  endtask

  task automatic write_io(input logic [7:0] a, input logic [7:0] d);
    int c;
    logic [3:0] p;
    c = cyc;
    IORQ_n = 1'b0;
    WR_n   = 1'b0;
    A      = a;
    D_in   = d;
    if (a == 8'h10) begin
      m_mask = d[3:0];
      p = m_req & m_mask;
      if (m_phase == PH_IDLE && p != 4'h0) begin
        push(K_FALL, c + 2, 8'h00, 8'h00);
        m_phase = PH_ASSERT;
      end else if (m_phase == PH_ASSERT && p == 4'h0) begin
        push(K_RISE, c + 2, 8'h01, 8'h01);
        m_phase = PH_IDLE;
      end
    end else if (a == 8'h12 && m_phase == PH_SERVICE) begin
      m_phase = PH_IDLE;
      p = m_req & m_mask;
      if (p != 4'h0) begin
        push(K_FALL, c + 2, 8'h00, 8'h00);
        m_phase = PH_ASSERT;
      end
    end
    tick();
    IORQ_n = 1'b1;
    WR_n   = 1'b1;
    ticks(4);
  endtask

  task automatic rd_io(input logic [7:0] a);
    int c;
    logic [7:0] e;
    bit mapped;
    c = cyc;
    IORQ_n = 1'b0;
    RD_n   = 1'b0;
    A      = a;
    mapped = 1'b1;
    if (a == 8'h10)      e = {4'h0, m_mask};
    else if (a == 8'h11) e = {4'h0, m_req};
    else begin
      e = m_last_rd;
      mapped = 1'b0;
    end
    if (mapped) begin
      push(K_RD, c + 1, e, e);
      m_last_rd = e;
    end
    tick();
    IORQ_n = 1'b1;
    RD_n   = 1'b1;
    ticks(2);
    if (!mapped) chk("io_data_unmapped", io_data, e);
  endtask

  task automatic do_ack();
    int c;
    logic [1:0] id;
    c = cyc;
    M1_n   = 1'b0;
    IORQ_n = 1'b0;
    if (m_phase == PH_ASSERT) begin
      id = lowest(m_req & m_mask);
      push(K_VEC, c, vec_for(8'h6C, id), vec_for(8'hF8, id));
      push(K_RISE, c + 1, 8'h01, 8'h01);
      m_svc = id;
      m_phase = PH_SERVICE;
    end
    ticks(2);
    M1_n   = 1'b1;
    IORQ_n = 1'b1;
    ticks(3);
  endtask

  task automatic do_reset();
    int c;
    c = cyc;
    RESET_n = 1'b0;
    if (m_phase == PH_ASSERT) push(K_RISE, c + 1, 8'h01, 8'h01);
    m_phase = PH_IDLE;
    tick();
    M1_n   = 1'b1;
    IORQ_n = 1'b1;
    tick();
    chk("rst_INT_n", {7'd0, INT_n}, 8'h01);
    chk("rst_int_vector", int_vector, 8'h6C);
    chk("rst_int_vector2", int_vector2, 8'hF8);
    chk("rst_io_data", io_data, 8'h00);
    chk("rst_oe", {6'd0, int_vec_oe, int_vec_oe2}, 8'h00);
    chk("rst_io_hit", {6'd0, io_hit, io_hit2}, 8'h00);
    m_mask = 4'h1;
    m_last_rd = 8'h00;
    RESET_n = 1'b1;
    c = cyc;
    if ((m_req & m_mask) != 4'h0) begin
      push(K_FALL, c + 3, 8'h00, 8'h00);
      m_phase = PH_ASSERT;
    end
    ticks(6);
  endtask

  initial begin
    int c;
    tick();
    do_reset();
    mon_en = 1'b1;

    // Single source, acknowledge, withdraw, re-raise.
    apply_req(4'b0001);
    do_ack();
    apply_req(4'b0000);
    rd_io(8'h10);
    apply_req(4'b0001);

    // Priority, EOI, withdrawal of the serviced source, wrap on dut2.
    write_io(8'h10, 8'h0F);
    apply_req(4'b1010);
    do_ack();
    write_io(8'h12, 8'hA5);
    do_ack();
    apply_req(4'b1000);
    do_ack();
    write_io(8'h12, 8'h00);
    apply_req(4'b0000);
    write_io(8'h12, 8'h00);

    // Masked request is visible in STATUS only; unmasking asserts INT_n.
    write_io(8'h10, 8'h0B);
    apply_req(4'b0100);
    rd_io(8'h11);
    rd_io(8'h10);
    write_io(8'h10, 8'h04);
    do_ack();
    write_io(8'h10, 8'h00);
    rd_io(8'h20);
    apply_req(4'b0000);

    // Request withdrawn before any acknowledge.
    write_io(8'h10, 8'h0F);
    apply_req(4'b0001);
    apply_req(4'b0000);

    // Reset while the acknowledge is still in progress.
    apply_req(4'b0001);
    c = cyc;
    M1_n   = 1'b0;
    IORQ_n = 1'b0;
    push(K_VEC, c, 8'h6C, 8'hF8);
    push(K_RISE, c + 1, 8'h01, 8'h01);
    m_phase = PH_SERVICE;
    ticks(2);
    do_reset();
    rd_io(8'h10);
    apply_req(4'b0000);

    // Randomised traffic.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 8))
        0, 1: apply_req(4'($urandom_range(0, 15)));
        2:    write_io(8'h10, 8'($urandom));
        3:    write_io(8'h12, 8'($urandom));
        4, 5: do_ack();
        6:    rd_io(($urandom_range(0, 1) == 1) ? 8'h10 : 8'h11);
        7:    rd_io(8'h3F);
        default: begin
          if ($urandom_range(0, 3) == 0) do_reset();
          else apply_req(4'($urandom_range(0, 15)));
        end
      endcase
    end

    ticks(8);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events: got %0d outstanding expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
